// File: rtl/add_num_pkg.sv
// Shared types and constants for the add-numbers AFU job sequencer.
package add_num_pkg;

  localparam int unsigned PAIRS      = 8;
  localparam int unsigned OPND_W     = 32;
  localparam int unsigned SUM_SLOT_W = 64;
  localparam int unsigned LINE_W     = PAIRS * SUM_SLOT_W;

  typedef logic [LINE_W-1:0] t_sum_line;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StAdd,
    StWrReq,
    StWrWait,
    StDone
  } t_job_state;

endpackage

// File: rtl/add_num_lane_adder.sv
// Combinational 8-lane adder: each 64-bit slot holds an operand pair {b, a} and
// is replaced by the zero-extended 33-bit sum a + b.
module add_num_lane_adder
  import add_num_pkg::*;
(
  input  logic [LINE_W-1:0] line_in,
  output t_sum_line         sum_line
);

  for (genvar i = 0; i < PAIRS; i++) begin : g_lane
    logic [OPND_W:0] sum;
    assign sum = {1'b0, line_in[i*SUM_SLOT_W +: OPND_W]}
               + {1'b0, line_in[i*SUM_SLOT_W + OPND_W +: OPND_W]};
    assign sum_line[i*SUM_SLOT_W +: SUM_SLOT_W] = {{(SUM_SLOT_W - OPND_W - 1){1'b0}}, sum};
  end

endmodule

// File: rtl/add_num_job_ctrl.sv
// Job sequencer for the add-numbers AFU: reads source lines on c0, adds packed
// operand pairs, writes result lines on c1, one transaction in flight at a time.
module add_num_job_ctrl
  import add_num_pkg::*;
#(
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [ADDR_W-1:0] cfg_dst_addr,
  input  logic [LEN_W-1:0]  cfg_num_lines,
  input  logic              start,
  input  logic              abort,
  input  logic              c0_almost_full,
  input  logic              c1_almost_full,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [511:0]      wr_req_data,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  lines_done,
  output logic [7:0]        start_ignored
);

  t_job_state        state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  num_q;
  // Completed-line count doubles as the line index for address generation.
  logic [LEN_W-1:0]  lines_done_q;
  logic [LINE_W-1:0] line_q;
  t_sum_line         sum_line, wr_data_q;
  logic              done_q, aborted_q, abort_pend_q;
  logic [7:0]        start_ign_q;
  logic              line_last;

  add_num_lane_adder u_lane_adder (
    .line_in  (line_q),
    .sum_line (sum_line)
  );

  assign line_last = (lines_done_q + LEN_W'(1)) == num_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = (cfg_num_lines == '0) ? StDone : StRdReq;
      StRdReq:  if (!c0_almost_full) state_d = StRdWait;
      StRdWait: if (rd_rsp_valid) state_d = StAdd;
      StAdd:    state_d = StWrReq;
      StWrReq:  if (!c1_almost_full) state_d = StWrWait;
      StWrWait: if (wr_rsp_valid) state_d = (abort_pend_q || line_last) ? StDone : StRdReq;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q        <= '0;
      dst_q        <= '0;
      num_q        <= '0;
      lines_done_q <= '0;
      line_q       <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      start_ign_q  <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        src_q        <= cfg_src_addr;
        dst_q        <= cfg_dst_addr;
        num_q        <= cfg_num_lines;
        lines_done_q <= '0;
        done_q       <= 1'b0;
        aborted_q    <= 1'b0;
        abort_pend_q <= 1'b0;
      end
      if (busy && abort) abort_pend_q <= 1'b1;
      if (busy && start && start_ign_q != 8'hFF) start_ign_q <= start_ign_q + 8'd1;
      if (state_q == StRdWait && rd_rsp_valid) line_q <= rd_rsp_data;
      if (state_q == StAdd) wr_data_q <= sum_line;
      if (state_q == StWrWait && wr_rsp_valid) begin
        lines_done_q <= lines_done_q + LEN_W'(1);
        if (abort_pend_q) aborted_q <= 1'b1;
      end
      if (state_q == StDone) begin
        done_q       <= 1'b1;
        abort_pend_q <= 1'b0;
      end
    end
  end

  assign busy          = (state_q != StIdle) && (state_q != StDone);
  assign rd_req_valid  = (state_q == StRdReq) && !c0_almost_full;
  assign rd_req_addr   = src_q + ADDR_W'(lines_done_q);
  assign wr_req_valid  = (state_q == StWrReq) && !c1_almost_full;
  assign wr_req_addr   = dst_q + ADDR_W'(lines_done_q);
  assign wr_req_data   = wr_data_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign lines_done    = lines_done_q;
  assign start_ignored = start_ign_q;

endmodule

// File: tb/tb_add_num_job_ctrl.sv
// Directed self-checking bench for add_num_job_ctrl with a small host memory
// responder that answers each request after a programmable delay.
module tb_add_num_job_ctrl;

  localparam int unsigned ADDR_W = 42;
  localparam int unsigned LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] cfg_src_addr = '0;
  logic [ADDR_W-1:0] cfg_dst_addr = '0;
  logic [LEN_W-1:0]  cfg_num_lines = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              c0_almost_full = 1'b0;
  logic              c1_almost_full = 1'b0;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid = 1'b0;
  logic [511:0]      rd_rsp_data = '0;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [511:0]      wr_req_data;
  logic              wr_rsp_valid = 1'b0;
  logic              busy, done, aborted;
  logic [LEN_W-1:0]  lines_done;
  logic [7:0]        start_ignored;

  add_num_job_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_src_addr   (cfg_src_addr),
    .cfg_dst_addr   (cfg_dst_addr),
    .cfg_num_lines  (cfg_num_lines),
    .start          (start),
    .abort          (abort),
    .c0_almost_full (c0_almost_full),
    .c1_almost_full (c1_almost_full),
    .rd_req_valid   (rd_req_valid),
    .rd_req_addr    (rd_req_addr),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_data    (rd_rsp_data),
    .wr_req_valid   (wr_req_valid),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .wr_rsp_valid   (wr_rsp_valid),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .lines_done     (lines_done),
    .start_ignored  (start_ignored)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0]      src_mem [16];
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] rd_log [$];
  logic [ADDR_W-1:0] wr_log [$];
  logic [511:0]      wr_data_log [$];
  int                rd_dly = 2;
  int                wr_dly = 2;
  int                wr_while_full = 0;

  // Requests are logged at the edge the DUT commits them; responses are driven
  // on the falling edge so they are stable at the next rising edge.
  always begin : responder
    int                rd_cnt;
    int                wr_cnt;
    logic [ADDR_W-1:0] rd_lat;
    logic [ADDR_W-1:0] off;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_lat = '0;
    forever begin
      @(posedge clk);
      if (rd_req_valid) begin
        rd_log.push_back(rd_req_addr);
        rd_lat = rd_req_addr;
        rd_cnt = rd_dly;
      end
      if (wr_req_valid) begin
        wr_log.push_back(wr_req_addr);
        wr_data_log.push_back(wr_req_data);
        wr_cnt = wr_dly;
        if (c1_almost_full) wr_while_full++;
      end
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      wr_rsp_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          off          = rd_lat - src_base;
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = src_mem[off[3:0]];
        end
      end
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) wr_rsp_valid = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns one falling edge after the start pulse.
  task automatic run_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [LEN_W-1:0] n);
    rd_log.delete();
    wr_log.delete();
    wr_data_log.delete();
    src_base      = s;
    cfg_src_addr  = s;
    cfg_dst_addr  = d;
    cfg_num_lines = n;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 1000 && !(done && !busy); k++) @(negedge clk);
    check(tag, {63'd0, done}, 64'd1);
  endtask

  function automatic logic [63:0] wr_slot(input int line, input int slot);
    logic [511:0] w;
    w = (line < wr_data_log.size()) ? wr_data_log[line] : '1;
    return w[slot*64 +: 64];
  endfunction

  function automatic logic [63:0] wr_addr_at(input int line);
    return (line < wr_log.size()) ? 64'(wr_log[line]) : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] line;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_aborted", {63'd0, aborted}, 64'd0);
    check("rst_lines_done", 64'(lines_done), 64'd0);
    check("rst_start_ignored", 64'(start_ignored), 64'd0);
    check("rst_rd_valid", {63'd0, rd_req_valid}, 64'd0);
    check("rst_wr_valid", {63'd0, wr_req_valid}, 64'd0);
    check("rst_wr_data", {63'd0, |wr_req_data}, 64'd0);

    // Single line: a = i, b = 10*i gives 11*i per slot
    for (int i = 0; i < 8; i++) begin
      line[i*64 +: 32]      = 32'(i);
      line[i*64 + 32 +: 32] = 32'(10 * i);
    end
    src_mem[0] = line;
    run_job(42'h100, 42'h200, 16'd1);
    wait_done("t1_done");
    check("t1_rd_count", 64'(rd_log.size()), 64'd1);
    check("t1_rd_addr", (rd_log.size() > 0) ? 64'(rd_log[0]) : 64'hDEAD, 64'h100);
    check("t1_wr_count", 64'(wr_log.size()), 64'd1);
    check("t1_wr_addr", wr_addr_at(0), 64'h200);
    for (int i = 0; i < 8; i++) check($sformatf("t1_slot%0d", i), wr_slot(0, i), 64'(11 * i));
    check("t1_lines_done", 64'(lines_done), 64'd1);
    check("t1_aborted", {63'd0, aborted}, 64'd0);

    // Overflow: every pair is all ones
    src_mem[0] = '1;
    run_job(42'h300, 42'h400, 16'd1);
    wait_done("t2_done");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_slot%0d", i), wr_slot(0, i), 64'h0000_0001_FFFF_FFFE);
    end

    // Four lines with c1 back-pressure while line 2 is in progress
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        line[i*64 +: 32]      = 32'(k * 100 + i);
        line[i*64 + 32 +: 32] = 32'd7;
      end
      src_mem[k] = line;
    end
    wr_while_full = 0;
    run_job(42'h1000, 42'h2000, 16'd4);
    for (int k = 0; k < 200 && rd_log.size() < 2; k++) @(negedge clk);
    check("t3_rd2_seen", {63'd0, rd_log.size() >= 2}, 64'd1);
    c1_almost_full = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_writes_during_hold", 64'(wr_log.size()), 64'd1);
    c1_almost_full = 1'b0;
    wait_done("t3_done");
    check("t3_wr_while_full", 64'(wr_while_full), 64'd0);
    check("t3_wr_count", 64'(wr_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_wr_addr%0d", k), wr_addr_at(k), 64'h2000 + 64'(k));
      check($sformatf("t3_l%0d_slot0", k), wr_slot(k, 0), 64'(k * 100 + 7));
      check($sformatf("t3_l%0d_slot7", k), wr_slot(k, 7), 64'(k * 100 + 14));
    end
    check("t3_lines_done", 64'(lines_done), 64'd4);

    // Zero-length job
    run_job(42'h10, 42'h20, 16'd0);
    @(negedge clk);
    check("t4_done", {63'd0, done}, 64'd1);
    check("t4_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("t4_rd_count", 64'(rd_log.size()), 64'd0);
    check("t4_wr_count", 64'(wr_log.size()), 64'd0);
    check("t4_lines_done", 64'(lines_done), 64'd0);

    // Ten-line job aborted while line 3 read is outstanding; a stray start mid-job
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) begin
        line[i*64 +: 32]      = 32'(k);
        line[i*64 + 32 +: 32] = 32'd1;
      end
      src_mem[k] = line;
    end
    run_job(42'h5000, 42'h6000, 16'd10);
    for (int k = 0; k < 200 && rd_log.size() < 3; k++) @(negedge clk);
    check("t5_rd3_seen", {63'd0, rd_log.size() >= 3}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5_done");
    check("t5_wr_count", 64'(wr_log.size()), 64'd3);
    check("t5_rd_count", 64'(rd_log.size()), 64'd3);
    check("t5_aborted", {63'd0, aborted}, 64'd1);
    check("t5_lines_done", 64'(lines_done), 64'd3);
    check("t5_start_ignored", 64'(start_ignored), 64'd1);
    check("t5_wr_addr2", wr_addr_at(2), 64'h6002);
    check("t5_l2_slot0", wr_slot(2, 0), 64'd3);

    // Reset while waiting for a write response; the response lands afterwards
    for (int i = 0; i < 8; i++) begin
      line[i*64 +: 32]      = 32'd5;
      line[i*64 + 32 +: 32] = 32'd5;
    end
    src_mem[0] = line;
    wr_dly = 6;
    run_job(42'h7000, 42'h8000, 16'd2);
    for (int k = 0; k < 200 && wr_log.size() < 1; k++) @(negedge clk);
    check("t6_wr1_seen", {63'd0, wr_log.size() >= 1}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    check("t6_aborted", {63'd0, aborted}, 64'd0);
    check("t6_lines_done", 64'(lines_done), 64'd0);
    check("t6_start_ignored", 64'(start_ignored), 64'd0);
    check("t6_wr_data", {63'd0, |wr_req_data}, 64'd0);
    check("t6_rd_count", 64'(rd_log.size()), 64'd1);
    check("t6_wr_count", 64'(wr_log.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
